mem_copy_dma: RTL and testbench

//  Word-copy engine that acts as a bus initiator on the Memory rd/wr/addr/data/ack interface.

---
 rtl/mem_copy_dma_if.sv | 29 ++
 rtl/mem_copy_dma.sv | 143 ++++++++++++++
 tb/tb_mem_copy_dma.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_dma_if.sv
// Control and memory-bus signals of the word-copy DMA engine.
// master is the engine; slave is the control side together with the memory responder.
interface mem_copy_dma_if #(
    parameter int unsigned LEN_WIDTH = 16
) ();
    logic                 start_i;
    logic [31:0]          src_i;
    logic [31:0]          dst_i;
    logic [LEN_WIDTH-1:0] len_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;
    logic                 rd_en_o;
    logic                 wr_en_o;
    logic [31:0]          addr_o;
    logic [31:0]          data_o;
    logic [31:0]          data_i;
    logic                 ack_i;

    modport master (
        input  start_i, src_i, dst_i, len_i, data_i, ack_i,
        output busy_o, done_o, err_o, rd_en_o, wr_en_o, addr_o, data_o
    );

    modport slave (
        output start_i, src_i, dst_i, len_i, data_i, ack_i,
        input  busy_o, done_o, err_o, rd_en_o, wr_en_o, addr_o, data_o
    );
endinterface

// File: rtl/mem_copy_dma.sv
// Word-copy bus initiator: reads a word from src, writes it to dst, repeats len times.
// Each bus access is guarded by a per-access timeout that parks the engine in a sticky error.
module mem_copy_dma #(
    parameter int unsigned ADDR_STEP   = 4,
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_copy_dma_if.master bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    // The counter only has to hold 0 .. TIMEOUT_CYC-1 before the engine leaves the state.
    localparam int unsigned     TO_W      = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam int unsigned     TO_LAST   = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
    localparam logic [TO_W-1:0] TO_LAST_V = TO_W'(TO_LAST);
    localparam logic [31:0]     STEP      = 32'(ADDR_STEP);

    logic [2:0]           state_q;
    logic [2:0]           state_d;
    logic [31:0]          src_q;
    logic [31:0]          dst_q;
    logic [31:0]          buf_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] len_dec;
    logic [TO_W-1:0]      to_cnt_q;
    logic                 err_q;

    logic in_access;
    logic start_ok;
    logic rd_ack;
    logic wr_ack;
    logic timeout_hit;
    logic last_word;

    assign in_access   = (state_q == S_RD) || (state_q == S_WR);
    assign start_ok    = (state_q == S_IDLE) && bus.start_i;
    assign rd_ack      = (state_q == S_RD) && bus.ack_i;
    assign wr_ack      = (state_q == S_WR) && bus.ack_i;
    assign len_dec     = len_q - LEN_WIDTH'(1);
    assign last_word   = (len_dec == '0);
    // An ack in the final allowed cycle still wins over the timeout.
    assign timeout_hit = (TIMEOUT_CYC != 0) && in_access && !bus.ack_i
                         && (to_cnt_q == TO_LAST_V);

    always_comb begin
        // NOTE: state_d gets a default first, so no branch can leave it unassigned and infer a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = (bus.len_i == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                if (bus.ack_i) begin
                    state_d = S_WR;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_WR: begin
                if (bus.ack_i) begin
                    state_d = last_word ? S_DONE : S_RD;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: every register here, the data buffer included, is a plain flop and takes the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q <= state_d;
            if (start_ok) begin
                src_q <= bus.src_i;
                dst_q <= bus.dst_i;
                len_q <= bus.len_i;
                err_q <= 1'b0;
            end
            if (rd_ack) begin
                buf_q <= bus.data_i;
            end
            if (wr_ack) begin
                src_q <= src_q + STEP;
                dst_q <= dst_q + STEP;
                len_q <= len_dec;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    // Restarts on every state change, so each RD and each WR gets a full budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if ((state_d != state_q) || (TIMEOUT_CYC == 0)) begin
            to_cnt_q <= '0;
        end else if (in_access) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    // Bus outputs decode straight from state, so an async reset clears them at once.
    assign bus.rd_en_o = (state_q == S_RD);
    assign bus.wr_en_o = (state_q == S_WR);
    assign bus.addr_o  = (state_q == S_RD) ? src_q :
                         (state_q == S_WR) ? dst_q : 32'd0;
    assign bus.data_o  = (state_q == S_WR) ? buf_q : 32'd0;
    assign bus.busy_o  = in_access;
    assign bus.done_o  = (state_q == S_DONE);
    assign bus.err_o   = err_q;

    a_rd_wr_exclusive: assert property (
        @(posedge clk) disable iff (!rst_n) !(bus.rd_en_o && bus.wr_en_o)
    );

    a_request_held: assert property (
        @(posedge clk) disable iff (!rst_n)
        (in_access && !bus.ack_i && !timeout_hit)
            |=> ($stable(bus.rd_en_o) && $stable(bus.wr_en_o)
                 && $stable(bus.addr_o) && $stable(bus.data_o))
    );
endmodule

// File: tb/tb_mem_copy_dma.sv
// Randomized scoreboard bench for mem_copy_dma: a word-level copy model predicts every bus access.
// A memory responder with variable wait states serves the engine; a monitor pops and compares.
module tb_mem_copy_dma;
    localparam int unsigned LEN_WIDTH   = 16;
    localparam int unsigned TIMEOUT_CYC = 8;
    localparam int          EV_DONE     = 1;
    localparam int          EV_ERR      = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mem_copy_dma_if #(.LEN_WIDTH(LEN_WIDTH)) bus ();

    mem_copy_dma #(
        .ADDR_STEP  (4),
        .LEN_WIDTH  (LEN_WIDTH),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    logic [31:0] exp_rd  [$];
    logic [63:0] exp_wr  [$];
    int          exp_evt [$];

    bit          hang;
    bit          noise;
    int unsigned min_wait;
    int unsigned max_wait;
    int unsigned wait_left;
    bit          in_req;
    int unsigned req_cycles;
    logic        err_prev;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Words never written read back as a fixed function of their address.
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0000 ^ {a[15:0], a[31:16]};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    // Reference: copy word i from s+4i to d+4i in order, recording the expected bus traffic.
    task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int unsigned l);
        for (int unsigned i = 0; i < l; i++) begin
            logic [31:0] ra;
            logic [31:0] wa;
            logic [31:0] v;
            ra = s + 32'(4 * i);
            wa = d + 32'(4 * i);
            v  = ref_rd(ra);
            ref_mem[wa] = v;
            exp_rd.push_back(ra);
            exp_wr.push_back({wa, v});
        end
        exp_evt.push_back(EV_DONE);
    endtask

    // Memory responder: acks after a random number of wait states; optional stray acks when idle.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ack_i  = 1'b0;
            bus.data_i = '0;
            in_req     = 1'b0;
        end else begin
            bus.ack_i  = 1'b0;
            bus.data_i = $urandom;
            if ((bus.rd_en_o || bus.wr_en_o) && !hang) begin
                if (!in_req) begin
                    in_req    = 1'b1;
                    wait_left = $urandom_range(max_wait, min_wait);
                end
                if (wait_left == 0) begin
                    bus.ack_i = 1'b1;
                    in_req    = 1'b0;
                    if (bus.rd_en_o) bus.data_i = mem_rd(bus.addr_o);
                    else             mem[bus.addr_o] = bus.data_o;
                end else begin
                    wait_left--;
                end
            end else begin
                in_req = 1'b0;
                if (noise && !hang) bus.ack_i = ($urandom_range(3, 0) == 0);
            end
        end
    end

    // Monitor: compares every completed access and every end event against the scoreboard.
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            err_prev = 1'b0;
        end else begin
            if (bus.rd_en_o || bus.wr_en_o) req_cycles++;
            if (bus.ack_i && (bus.rd_en_o || bus.wr_en_o))
                check("rd_wr_exclusive", 32'(bus.rd_en_o & bus.wr_en_o), 32'd0);
            if (bus.ack_i && bus.rd_en_o) begin
                check("rd_pending", 32'(exp_rd.size() != 0), 32'd1);
                if (exp_rd.size() != 0) check("rd_addr", bus.addr_o, exp_rd.pop_front());
            end
            if (bus.ack_i && bus.wr_en_o) begin
                check("wr_pending", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) begin
                    logic [63:0] w;
                    w = exp_wr.pop_front();
                    check("wr_addr", bus.addr_o, w[63:32]);
                    check("wr_data", bus.data_o, w[31:0]);
                end
            end
            if (bus.done_o) begin
                check("evt_pending_done", 32'(exp_evt.size() != 0), 32'd1);
                if (exp_evt.size() != 0) check("end_event_done", 32'(exp_evt.pop_front()), 32'(EV_DONE));
            end
            if (bus.err_o && !err_prev) begin
                check("evt_pending_err", 32'(exp_evt.size() != 0), 32'd1);
                if (exp_evt.size() != 0) check("end_event_err", 32'(exp_evt.pop_front()), 32'(EV_ERR));
            end
            err_prev = bus.err_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Issues a one-cycle start and returns just after the edge that samples it.
    task automatic launch(input logic [31:0] s, input logic [31:0] d, input int unsigned l,
                          input bit expect_err);
        if (expect_err) exp_evt.push_back(EV_ERR);
        else            model_copy(s, d, l);
        bus.start_i = 1'b1;
        bus.src_i   = s;
        bus.dst_i   = d;
        bus.len_i   = LEN_WIDTH'(l);
        step();
        bus.start_i = 1'b0;
        bus.src_i   = $urandom;
        bus.dst_i   = $urandom;
        bus.len_i   = LEN_WIDTH'($urandom);
    endtask

    task automatic wait_end(output int cycles);
        cycles = 1;
        while (!(bus.done_o || bus.err_o) && cycles < 500) begin
            step();
            cycles++;
        end
        check("end_seen", 32'(bus.done_o | bus.err_o), 32'd1);
    endtask

    task automatic check_quiet(input string name);
        check(name, {27'd0, bus.busy_o, bus.done_o, bus.err_o, bus.rd_en_o, bus.wr_en_o}, 32'd0);
        check({name, "_addr"}, bus.addr_o, 32'd0);
        check({name, "_data"}, bus.data_o, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int cyc;
        int n;
        int unsigned r0;
        n_checks    = 0;
        n_fail      = 0;
        req_cycles  = 0;
        err_prev    = 1'b0;
        hang        = 1'b0;
        noise       = 1'b0;
        min_wait    = 0;
        max_wait    = 0;
        bus.start_i = 1'b0;
        bus.src_i   = '0;
        bus.dst_i   = '0;
        bus.len_i   = '0;

        #12;
        check_quiet("reset_outputs");
        #10 rst_n = 1'b1;
        step();
        check_quiet("idle_after_reset");

        // Four words through a one-wait-state memory.
        min_wait = 1;
        max_wait = 1;
        for (int i = 0; i < 4; i++) begin
            mem[32'h100 + 32'(4 * i)]     = 32'hA0 + 32'(i);
            ref_mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
        end
        launch(32'h100, 32'h200, 4, 1'b0);
        check("busy_after_start", 32'(bus.busy_o), 32'd1);
        wait_end(cyc);
        check("t1_done", 32'(bus.done_o), 32'd1);
        check("t1_err", 32'(bus.err_o), 32'd0);
        check("t1_busy_in_done", 32'(bus.busy_o), 32'd0);
        step();
        check("t1_done_single_pulse", 32'(bus.done_o), 32'd0);
        for (int i = 0; i < 4; i++) check("t1_mem_dst", mem_rd(32'h200 + 32'(4 * i)), 32'hA0 + 32'(i));

        // Zero-length copy with stray acks: done right away, no bus activity.
        noise = 1'b1;
        r0 = req_cycles;
        launch(32'h500, 32'h600, 0, 1'b0);
        wait_end(cyc);
        check("len0_latency", 32'(cyc), 32'd1);
        check("len0_done", 32'(bus.done_o), 32'd1);
        step();
        check("len0_no_requests", req_cycles - r0, 32'd0);
        check("len0_done_single_pulse", 32'(bus.done_o), 32'd0);

        // Zero-wait memory: 2*len+1 cycles from start to done.
        min_wait = 0;
        max_wait = 0;
        launch(32'h700, 32'h800, 3, 1'b0);
        wait_end(cyc);
        check("zero_wait_latency", 32'(cyc), 32'd7);
        step();

        // Source address wraps past the top of the address space.
        max_wait = 2;
        launch(32'hFFFF_FFFC, 32'h900, 2, 1'b0);
        wait_end(cyc);
        check("wrap_done", 32'(bus.done_o), 32'd1);
        step();

        // A second start during a copy is ignored.
        launch(32'hA00, 32'hB00, 6, 1'b0);
        step();
        step();
        bus.start_i = 1'b1;
        bus.src_i   = 32'hC00;
        bus.dst_i   = 32'hC80;
        bus.len_i   = LEN_WIDTH'(1);
        step();
        bus.start_i = 1'b0;
        check("busy_through_restart", 32'(bus.busy_o), 32'd1);
        wait_end(cyc);
        check("restart_ignored_done", 32'(bus.done_o), 32'd1);
        step();

        // Silent memory: timeout, sticky error, cleared by the next start.
        hang  = 1'b1;
        noise = 1'b0;
        launch(32'hD00, 32'hE00, 2, 1'b1);
        check("to_rd_asserted", 32'(bus.rd_en_o), 32'd1);
        n = 0;
        while (!bus.err_o && n < 50) begin
            step();
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TIMEOUT_CYC));
        check("to_err", 32'(bus.err_o), 32'd1);
        check("to_busy_low", 32'(bus.busy_o), 32'd0);
        check("to_rd_dropped", 32'(bus.rd_en_o), 32'd0);
        step();
        step();
        step();
        check("err_sticky", 32'(bus.err_o), 32'd1);
        hang = 1'b0;
        launch(32'hD00, 32'hE00, 1, 1'b0);
        check("err_cleared_by_start", 32'(bus.err_o), 32'd0);
        wait_end(cyc);
        check("after_err_done", 32'(bus.done_o), 32'd1);
        step();

        // Randomized copies, possibly overlapping, with random wait states and stray acks.
        noise = 1'b1;
        for (int k = 0; k < 12; k++) begin
            logic [31:0] s;
            logic [31:0] d;
            int unsigned l;
            min_wait = 0;
            max_wait = $urandom_range(3, 0);
            s = 32'h2000 + 32'(4 * $urandom_range(63, 0));
            d = 32'h2000 + 32'(4 * $urandom_range(63, 0));
            l = $urandom_range(8, 0);
            launch(s, d, l, 1'b0);
            wait_end(cyc);
            check("rand_done", 32'(bus.done_o), 32'd1);
            step();
        end

        // Asynchronous reset while a write is pending, then a fresh one-word copy.
        noise    = 1'b0;
        min_wait = 0;
        max_wait = 0;
        launch(32'h3000, 32'h3100, 3, 1'b0);
        n = 0;
        while (!bus.wr_en_o && n < 20) begin
            step();
            n++;
        end
        check("reached_wr", 32'(bus.wr_en_o), 32'd1);
        hang = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_quiet("async_reset_outputs");
        step();
        step();
        exp_rd.delete();
        exp_wr.delete();
        exp_evt.delete();
        hang  = 1'b0;
        rst_n = 1'b1;
        step();
        check_quiet("idle_after_mid_reset");
        launch(32'h3200, 32'h3300, 1, 1'b0);
        wait_end(cyc);
        check("post_reset_done", 32'(bus.done_o), 32'd1);
        check("post_reset_err", 32'(bus.err_o), 32'd0);
        step();
        check("post_reset_mem", mem_rd(32'h3300), dflt(32'h3200));

        step();
        step();
        check("sb_rd_drained", 32'(exp_rd.size()), 32'd0);
        check("sb_wr_drained", 32'(exp_wr.size()), 32'd0);
        check("sb_evt_drained", 32'(exp_evt.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
